// File: rtl/sv_audio_dma.sv
// Audio DMA reader: fetches packed 4-bit PCM over a request/acknowledge read
// port, keeps one byte prefetched, and plays one nibble per sample tick.
module sv_audio_dma #(
    parameter logic [23:0] DIV = 24'd83886
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  DMA_addr_lo,
    input  logic [7:0]  DMA_addr_hi,
    input  logic [7:0]  DMA_length,
    input  logic [7:0]  DMA_ctrl,
    input  logic [7:0]  DMA_trigger,
    input  logic        trig_we,
    output logic        mem_rd,
    output logic [15:0] mem_addr,
    input  logic [7:0]  mem_din,
    input  logic        mem_ack,
    output logic [3:0]  sample,
    output logic        busy,
    output logic        done,
    output logic        underrun
);

    typedef enum logic [1:0] {IDLE, FILL, PLAY} state_t;
    // PH_NEXT: the low nibble has been played, the next tick needs a new byte.
    typedef enum logic [1:0] {PH_HIGH, PH_LOW, PH_NEXT} phase_t;

    state_t      state, state_next;
    phase_t      phase;
    logic [23:0] acc;
    logic        base_tick;
    logic [1:0]  rate_cnt;
    logic        sample_tick;
    logic [15:0] addr;
    logic [12:0] fetch_cnt;
    logic [12:0] play_cnt;
    logic [12:0] blk_len;
    logic [7:0]  buf_data;
    logic        buf_valid;
    logic [7:0]  cur;
    logic        start;
    logic        stop;
    logic        ack_ok;
    logic        unused_bits;

    assign start       = trig_we && DMA_trigger[7];
    assign stop        = trig_we && !DMA_trigger[7];
    // A trigger write wins over an acknowledge in the same cycle.
    assign ack_ok      = mem_ack && mem_rd && !trig_we;
    assign sample_tick = base_tick && (rate_cnt == DMA_ctrl[1:0]);
    assign blk_len     = {(DMA_length == 8'd0) ? 9'd256 : {1'b0, DMA_length}, 4'b0000};
    assign unused_bits = ^{DMA_ctrl[7:2], DMA_trigger[6:0]};

    // Phase accumulator: carry out is the one-cycle base tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= '0;
            base_tick <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register updates from pre-edge values.
            {base_tick, acc} <= {1'b0, acc} + {1'b0, DIV};
        end
    end

    // Rate divider: counts base ticks, wraps at the programmed interval.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rate_cnt <= 2'd0;
        else if (start)
            rate_cnt <= 2'd0;
        else if (base_tick)
            rate_cnt <= (rate_cnt == DMA_ctrl[1:0]) ? 2'd0 : rate_cnt + 2'd1;
    end

    // State register and registered busy flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
        end else begin
            state <= state_next;
            busy  <= (state_next != IDLE);
        end
    end

    // Next-state decode: trigger writes override the playback flow.
    always_comb begin
        // NOTE: default assigned first so no latch is inferred.
        state_next = state;
        if (start) begin
            state_next = FILL;
        end else if (stop) begin
            state_next = IDLE;
        end else begin
            case (state)
                FILL: if (buf_valid) state_next = PLAY;
                PLAY: begin
                    if (sample_tick && phase == PH_NEXT) begin
                        if (play_cnt == 13'd0)
                            state_next = IDLE;
                        else if (!buf_valid)
                            state_next = FILL;
                    end
                end
                default: state_next = state;
            endcase
        end
    end

    // Fetch engine and nibble playback datapath.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: data registers are reset too so the outputs start known.
            mem_rd    <= 1'b0;
            mem_addr  <= 16'h0000;
            sample    <= 4'h0;
            done      <= 1'b0;
            underrun  <= 1'b0;
            addr      <= 16'h0000;
            fetch_cnt <= 13'd0;
            play_cnt  <= 13'd0;
            buf_data  <= 8'h00;
            buf_valid <= 1'b0;
            cur       <= 8'h00;
            phase     <= PH_HIGH;
        end else begin
            done <= 1'b0;
            if (start) begin
                addr      <= {DMA_addr_hi, DMA_addr_lo};
                fetch_cnt <= blk_len;
                play_cnt  <= blk_len;
                buf_valid <= 1'b0;
                underrun  <= 1'b0;
                mem_rd    <= 1'b0;
            end else if (stop) begin
                mem_rd <= 1'b0;
                sample <= 4'h0;
            end else begin
                // Fetch: one outstanding read, only into an empty buffer.
                if (ack_ok) begin
                    buf_data  <= mem_din;
                    buf_valid <= 1'b1;
                    addr      <= addr + 16'd1;
                    fetch_cnt <= fetch_cnt - 13'd1;
                    mem_rd    <= 1'b0;
                end else if (!mem_rd && state != IDLE && fetch_cnt != 13'd0 && !buf_valid) begin
                    mem_rd   <= 1'b1;
                    mem_addr <= addr;
                end

                // Playback: buffer valid and an outstanding read never coexist.
                case (state)
                    FILL: begin
                        if (buf_valid) begin
                            cur       <= buf_data;
                            buf_valid <= 1'b0;
                            phase     <= PH_HIGH;
                        end
                    end
                    PLAY: begin
                        if (sample_tick) begin
                            case (phase)
                                PH_HIGH: begin
                                    sample <= cur[7:4];
                                    phase  <= PH_LOW;
                                end
                                PH_LOW: begin
                                    sample   <= cur[3:0];
                                    play_cnt <= play_cnt - 13'd1;
                                    phase    <= PH_NEXT;
                                end
                                default: begin
                                    if (play_cnt == 13'd0) begin
                                        sample <= 4'h0;
                                        done   <= 1'b1;
                                    end else if (buf_valid) begin
                                        cur       <= buf_data;
                                        sample    <= buf_data[7:4];
                                        buf_valid <= 1'b0;
                                        phase     <= PH_LOW;
                                    end else begin
                                        underrun <= 1'b1;
                                        sample   <= 4'h0;
                                    end
                                end
                            endcase
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sv_audio_dma.sv
// Testbench for sv_audio_dma: table of block transfers checked by address and
// nibble scoreboards, plus hand-written stop and restart sequences.
module tb_sv_audio_dma;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  DMA_addr_lo, DMA_addr_hi, DMA_length, DMA_ctrl, DMA_trigger;
    logic        trig_we;
    logic        mem_rd;
    logic [15:0] mem_addr;
    logic [7:0]  mem_din;
    logic        mem_ack;
    logic [3:0]  sample;
    logic        busy, done, underrun;

    sv_audio_dma #(.DIV(24'h80_0000)) dut (
        .clk(clk), .rst_n(rst_n),
        .DMA_addr_lo(DMA_addr_lo), .DMA_addr_hi(DMA_addr_hi),
        .DMA_length(DMA_length), .DMA_ctrl(DMA_ctrl),
        .DMA_trigger(DMA_trigger), .trig_we(trig_we),
        .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_din(mem_din), .mem_ack(mem_ack),
        .sample(sample), .busy(busy), .done(done), .underrun(underrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  len;
        logic [1:0]  rate;
        int          lat;
        int          exp_reads;
        logic        exp_under;
        logic        chk_gap;
        logic [15:0] exp_last;
    } vec_t;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [15:0] exp_addr_q[$];
    logic [3:0]  exp_nib_q[$];
    bit          auto_resp = 0;
    bit          chk_addr  = 0;
    bit          mon_en    = 0;
    bit          chk_gap   = 0;
    bit          have_last = 0;
    int          lat = 0, wcnt = 0, n_reads = 0;
    int          nib_seen = 0, zero_stall = 0, done_cnt = 0;
    int          cyc = 0, last_cyc = 0, exp_gap = 2;
    logic [15:0] last_addr = 16'h0000;
    logic [3:0]  prev_s = 4'h0;

    // Memory contents: no zero nibbles and no two adjacent equal nibbles,
    // so every played nibble shows up as a change on sample.
    function automatic logic [7:0] mem_val(input logic [15:0] a);
        logic [3:0] h, l;
        h = 4'(a % 16'd15) + 4'd1;
        l = 4'((a + 16'd7) % 16'd15) + 4'd1;
        return {h, l};
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock: clear strobes, then act as the memory when in auto mode.
    task automatic step();
        @(posedge clk);
        #1;
        trig_we = 1'b0;
        if (!auto_resp) begin
            mem_ack = 1'b0;
        end else if (mem_ack) begin
            mem_ack = 1'b0;
        end else if (mem_rd) begin
            if (wcnt >= lat) begin
                mem_ack   = 1'b1;
                mem_din   = mem_val(mem_addr);
                n_reads++;
                last_addr = mem_addr;
                wcnt      = 0;
                if (chk_addr) begin
                    if (exp_addr_q.size() == 0)
                        check("reads_pending", exp_addr_q.size(), 1);
                    else
                        check("read_addr", int'(mem_addr), int'(exp_addr_q.pop_front()));
                end
            end else begin
                wcnt++;
            end
        end else begin
            wcnt = 0;
        end
    endtask

    // Output monitor: pops expected nibbles as sample changes.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (done) begin
                done_cnt++;
                check("done_sample_zero", int'(sample), 0);
            end
            if (mon_en && sample != prev_s && sample != 4'h0) begin
                if (exp_nib_q.size() == 0)
                    check("nibbles_pending", exp_nib_q.size(), 1);
                else
                    check("nibble", int'(sample), int'(exp_nib_q.pop_front()));
                if (chk_gap && have_last)
                    check("nibble_gap", cyc - last_cyc, exp_gap);
                have_last = 1;
                last_cyc  = cyc;
                nib_seen++;
            end
            if (mon_en && busy && sample == 4'h0 && nib_seen > 0)
                zero_stall++;
            prev_s = sample;
        end
    end

    task automatic run_row(input vec_t v, input int idx);
        int budget;
        exp_addr_q.delete();
        exp_nib_q.delete();
        for (int i = 0; i < v.exp_reads; i++) begin
            logic [15:0] a;
            logic [7:0]  b;
            a = v.addr + 16'(i);
            b = mem_val(a);
            exp_addr_q.push_back(a);
            exp_nib_q.push_back(b[7:4]);
            exp_nib_q.push_back(b[3:0]);
        end
        lat = v.lat; wcnt = 0; n_reads = 0; nib_seen = 0; zero_stall = 0;
        done_cnt = 0; have_last = 0; chk_gap = v.chk_gap;
        exp_gap = (int'(v.rate) + 1) * 2;
        auto_resp = 1; chk_addr = 1; mon_en = 1;
        DMA_addr_lo = v.addr[7:0];
        DMA_addr_hi = v.addr[15:8];
        DMA_length  = v.len;
        DMA_ctrl    = {6'b0, v.rate};
        DMA_trigger = 8'h80;
        trig_we     = 1'b1;
        step();
        budget = v.exp_reads * (4 * (int'(v.rate) + 1) + v.lat + 8) + 200;
        for (int c = 0; c < budget && done_cnt == 0; c++) step();
        for (int c = 0; c < 3; c++) step();
        $display("[TB] row %0d addr=%h len=%0d rate=%0d lat=%0d finished", idx, v.addr, v.len, v.rate, v.lat);
        check("done_once", done_cnt, 1);
        check("busy_after_done", int'(busy), 0);
        check("read_count", n_reads, v.exp_reads);
        check("last_read_addr", int'(last_addr), int'(v.exp_last));
        check("nibble_count", nib_seen, 2 * v.exp_reads);
        check("underrun_flag", int'(underrun), int'(v.exp_under));
        check("addr_queue_empty", exp_addr_q.size(), 0);
        if (v.exp_under)
            check("stall_sample_zero", int'(zero_stall > 0), 1);
        mon_en = 0;
    endtask

    vec_t vecs[5];

    initial begin
        vecs[0] = '{16'h1234, 8'd1, 2'd0, 0,  16,   1'b0, 1'b1, 16'h1243};
        vecs[1] = '{16'hFFF8, 8'd1, 2'd0, 0,  16,   1'b0, 1'b1, 16'h0007};
        vecs[2] = '{16'h0100, 8'd1, 2'd0, 40, 16,   1'b1, 1'b0, 16'h010F};
        vecs[3] = '{16'h2000, 8'd2, 2'd3, 2,  32,   1'b0, 1'b1, 16'h201F};
        vecs[4] = '{16'hF000, 8'd0, 2'd0, 0,  4096, 1'b0, 1'b1, 16'hFFFF};

        rst_n = 1'b0;
        DMA_addr_lo = 8'h00; DMA_addr_hi = 8'h00; DMA_length = 8'h00;
        DMA_ctrl = 8'h00; DMA_trigger = 8'h00; trig_we = 1'b0;
        mem_din = 8'h00; mem_ack = 1'b0;
        #22;
        check("reset_mem_rd", int'(mem_rd), 0);
        check("reset_mem_addr", int'(mem_addr), 0);
        check("reset_sample", int'(sample), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_underrun", int'(underrun), 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 4; i++) run_row(vecs[i], i);

        // Stop mid-block: everything drops next cycle, no done pulse.
        auto_resp = 1; chk_addr = 0; mon_en = 0; lat = 0; wcnt = 0;
        DMA_addr_lo = 8'h00; DMA_addr_hi = 8'h30; DMA_length = 8'd4; DMA_ctrl = 8'h01;
        DMA_trigger = 8'h80; trig_we = 1'b1;
        step();
        for (int c = 0; c < 40; c++) step();
        check("stop_pre_busy", int'(busy), 1);
        done_cnt = 0;
        DMA_trigger = 8'h00; trig_we = 1'b1;
        step();
        check("stop_busy", int'(busy), 0);
        check("stop_sample", int'(sample), 0);
        check("stop_mem_rd", int'(mem_rd), 0);
        for (int c = 0; c < 30; c++) step();
        check("stop_no_done", done_cnt, 0);
        check("stop_still_idle", int'(busy), 0);

        // Restart during an underrun stall with an ack in the same cycle.
        auto_resp = 0;
        DMA_addr_lo = 8'h00; DMA_addr_hi = 8'h50; DMA_length = 8'd1; DMA_ctrl = 8'h00;
        DMA_trigger = 8'h80; trig_we = 1'b1;
        step();
        for (int c = 0; c < 20 && !mem_rd; c++) step();
        check("rs_first_req", int'(mem_rd), 1);
        mem_din = 8'h31; mem_ack = 1'b1;
        step();
        for (int c = 0; c < 20 && !mem_rd; c++) step();
        check("rs_second_req", int'(mem_rd), 1);
        for (int c = 0; c < 60 && !underrun; c++) step();
        check("rs_underrun_set", int'(underrun), 1);
        check("rs_stall_sample", int'(sample), 0);
        check("rs_rd_held", int'(mem_rd), 1);
        DMA_addr_lo = 8'h00; DMA_addr_hi = 8'h40;
        DMA_trigger = 8'h80; trig_we = 1'b1;
        mem_din = 8'h9A; mem_ack = 1'b1;
        step();
        check("rs_underrun_clr", int'(underrun), 0);
        check("rs_rd_dropped", int'(mem_rd), 0);
        check("rs_busy", int'(busy), 1);
        for (int c = 0; c < 20 && !mem_rd; c++) step();
        check("rs_new_req", int'(mem_rd), 1);
        check("rs_new_addr", int'(mem_addr), 16'h4000);
        mem_din = 8'h5C; mem_ack = 1'b1;
        step();
        for (int c = 0; c < 20 && sample == 4'h0; c++) step();
        check("rs_first_nibble", int'(sample), 5);
        DMA_trigger = 8'h00; trig_we = 1'b1;
        step();
        step();

        run_row(vecs[4], 4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
